// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand stage: opcodes, funct codes, FSM states
// and the R-type funct decoder.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b111;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;

  localparam logic [5:0] OP_RTYPE = 6'b000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic       legal;
    logic [2:0] op;
  } decode_t;

  function automatic decode_t decode_instr(input logic [5:0] op, input logic [5:0] funct);
    decode_t d;
    d.legal = (op == OP_RTYPE);
    d.op    = ALU_AND;
    case (funct)
      FUNCT_AND: d.op = ALU_AND;
      FUNCT_OR:  d.op = ALU_OR;
      FUNCT_ADD: d.op = ALU_ADD;
      FUNCT_XOR: d.op = ALU_XOR;
      FUNCT_SUB: d.op = ALU_SUB;
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_file_32x32.sv
// 32x32 register file: three asynchronous read ports, one synchronous write
// port, register 0 hardwired to zero, synchronous active-low clear.
module reg_file_32x32 #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        rs_addr,
  output logic [DATA_W-1:0] rs_data,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rt_data,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rs_data  = (rs_addr  == 5'd0) ? '0 : regs[rs_addr];
  assign rt_data  = (rt_addr  == 5'd0) ? '0 : regs[rt_addr];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand/writeback sequencer in front of the 32-bit ALU: IDLE accepts and
// decodes an R-type instruction, EXEC captures the ALU result, WB writes rd.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic [DATA_W-1:0] alu_i1,
  output logic [DATA_W-1:0] alu_i2,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              done,
  output logic              err
);

  state_e            state, state_nxt;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic              accept;
  decode_t           dec;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              unused_shamt;

  assign unused_shamt = ^in_instr[10:6];

  assign in_ready = (state == IDLE) && !cfg_we;
  assign accept   = in_valid && in_ready;
  assign dec      = decode_instr(in_instr[31:26], in_instr[5:0]);
  assign done     = (state == WB);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && dec.legal) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      alu_i1 <= '0;
      alu_i2 <= '0;
      alu_op <= ALU_AND;
      rd_q   <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= accept && !dec.legal;
      // Operands only move on a legal accept so they hold through EXEC and beyond.
      if (accept && dec.legal) begin
        alu_i1 <= rs_val;
        alu_i2 <= rt_val;
        alu_op <= dec.op;
        rd_q   <= in_instr[15:11];
      end
      if (state == EXEC) result <= alu_out;
    end
  end

  // cfg writes only exist in IDLE and writeback only in WB, so they never collide.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = cfg_addr;
    rf_wdata = cfg_data;
    if (state == WB) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q;
      rf_wdata = result;
    end else if (state == IDLE && cfg_we) begin
      rf_we = 1'b1;
    end
  end

  reg_file_32x32 #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_addr  (in_instr[25:21]),
    .rs_data  (rs_val),
    .rt_addr  (in_instr[20:16]),
    .rt_data  (rt_val),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata)
  );

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Sequencing stage directly upstream of the 32-bit ALU. Accepts R-type instruction words over a valid/ready handshake and reads rs/rt from an internal register file. Decodes funct into the 3-bit ALU opcode and drives the ALU operands. Captures the ALU result and writes it back to rd. Also provides a config write port and a debug read port so the bench can preload and inspect registers.

Parameters:
DATA_W, 32, datapath and register width; fixed at 32 for this design.
NREGS, 32, register count; index width is 5 and register 0 always reads zero.

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  instruction valid
in_ready  out  1  stage can accept; = (state==IDLE) & ~cfg_we
in_instr  in  32  [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [5:0] funct
alu_i1  out  32  ALU operand 1 (rs value), registered
alu_i2  out  32  ALU operand 2 (rt value), registered
alu_op  out  3  ALU opcode, registered
alu_out  in  32  combinational ALU result
cfg_we  in  1  register preload strobe; honoured only in IDLE
cfg_addr  in  5  preload index
cfg_data  in  32  preload value
dbg_addr  in  5  debug read index
dbg_data  out  32  combinational read of register dbg_addr
done  out  1  one-cycle pulse: instruction completed
err  out  1  one-cycle pulse: instruction rejected

Behaviour:
- Reset is synchronous and active-low, sampled on the clk edge. When rst_n is low at an edge:
  - state becomes IDLE;
  - all registers, alu_i1, alu_i2, result reg and instr latch clear to 0;
  - alu_op = 3'b000; done = 0; err = 0.
- Reset mid-operation aborts the instruction: no writeback and no done.
- FSM states are IDLE, EXEC and WB.
- IDLE:
  - cfg_we=1 writes cfg_data to cfg_addr; a write to index 0 is ignored.
  - cfg_we forces in_ready=0, so a same-cycle in_valid is not accepted.
  - On in_valid & in_ready, latch rd, load alu_i1/alu_i2 from rs/rt and decode.
- Decode (only when op==6'b000000), funct to alu_op:
  - 100100 -> 000 (and)
  - 100101 -> 001 (or)
  - 100000 -> 010 (add)
  - 100110 -> 111 (xor)
  - 100010 -> 110 (sub)
- Any other op or funct is illegal: stay in IDLE, err=1 in the next cycle, no register change, alu_op unchanged.
- A legal instruction moves to EXEC.
- EXEC (1 cycle): alu_i1, alu_i2 and alu_op are stable. The result reg captures alu_out at the end of the cycle. Next state is WB.
- WB (1 cycle):
  - result reg is written to rd at the end of the cycle, unless rd==0;
  - done=1 during this cycle;
  - next state is IDLE.
- Latency: accept at edge N, EXEC in cycle N+1, done and WB in cycle N+2. The new value is visible on dbg_data from cycle N+3.
- Throughput is one instruction per 3 cycles.
- alu_i1, alu_i2 and alu_op hold their last values outside EXEC.
- Arithmetic is modulo 2^32; there is no overflow flag. The ALU zero output is not consumed.
- dbg_data is an asynchronous read. Index 0 always returns 0.

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode constants: ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_XOR=111, ALU_SUB=110;
  - funct constants;
  - R-type opcode constant;
  - FSM state encoding.
- One sub-module, reg_file_32x32:
  - 3 asynchronous read ports (rs, rt, dbg);
  - 1 synchronous write port, muxed between cfg and WB;
  - register 0 hardwired to zero;
  - synchronous active-low clear.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> in_ready=1 after the first edge; dbg_data=0 for all 32 indices; done=err=0.
- Add: preload r1=0x0000000F, r2=0x00000001; issue 0x00221820 -> in EXEC alu_op=010, alu_i1=0xF, alu_i2=0x1; done 2 cycles after accept; r3=0x00000010.
- Sub: issue 0x00412022 -> alu_op=110; r4=0xFFFFFFF2.
- rd=0: issue 0x00220024 -> alu_op=000 and done pulses; r0 still reads 0.
- Illegal funct: issue 0x0022182A, then 0x20220005 -> err pulses once per instruction; r3 unchanged; in_ready=1 the following cycle.
- Simultaneous and abort cases:
  - cfg_we with in_valid in IDLE -> in_ready=0; cfg write lands; instruction accepted next cycle.
  - rst_n=0 during EXEC of an add -> no done; all registers read 0.
